// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;
endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: producer handshake, transmitter write port and queue status
// master = producer/transmitter side, slave = the queue itself
interface uart_tx_queue_if
  import uart_pkg::*;
#(parameter int DEPTH = 16);
  logic [UART_DATA_W-1:0] wdata, din;
  logic wvalid, wready, wr_en, tx_busy, empty, full, overflow, ovf_clr;
  logic [$clog2(DEPTH):0] count;
  modport master (output wdata, wvalid, tx_busy, ovf_clr,
                  input wready, din, wr_en, count, empty, full, overflow);
  modport slave (input wdata, wvalid, tx_busy, ovf_clr,
                 output wready, din, wr_en, count, empty, full, overflow);
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read
// ports: push/wdata in, pop in, rdata = head entry, count/full/empty status
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_50m) if (push) mem[wptr_q] <= wdata;
  assign rdata = mem[rptr_q];
  assign count = count_q;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue that paces writes into the uart transmitter on tx_busy
// ports: clk_50m, rst (sync, active-high), q = producer handshake + transmitter port + status
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input logic clk_50m,
  input logic rst,
  uart_tx_queue_if.slave q
);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [UART_DATA_W-1:0] din_q, din_d, head;
  logic wr_en_q, wr_en_d, ovf_q, ovf_d, push, pop, full, empty;
  assign push = q.wvalid && !full;
  sync_fifo #(.W(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_50m(clk_50m), .rst(rst), .push(push), .pop(pop), .wdata(q.wdata),
    .rdata(head), .count(q.count), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    din_d = din_q;
    wr_en_d = 1'b0;
    pop = 1'b0;
    ovf_d = (q.wvalid && full) || (ovf_q && !q.ovf_clr);
    unique case (state_q)
      IDLE: if (!empty && !q.tx_busy) begin
        pop = 1'b1;
        din_d = head;
        wr_en_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (q.tx_busy) state_d = WAIT_DONE;
      else begin
        // a strobe the transmitter never acknowledged must not stall the queue
        timer_d = timer_q + 1'b1;
        if (timer_d == TW'(BUSY_TIMEOUT - 1)) state_d = IDLE;
      end
      WAIT_DONE: if (!q.tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      din_q <= '0;
      wr_en_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      din_q <= din_d;
      wr_en_q <= wr_en_d;
      ovf_q <= ovf_d;
    end
  end
  assign q.wready = !full;
  assign q.full = full;
  assign q.empty = empty;
  assign q.din = din_q;
  assign q.wr_en = wr_en_q;
  assign q.overflow = ovf_q;
endmodule
